// File: rtl/video_pkg.sv
// video_pkg: shared 640x480@60 timing defaults, pixel control word and colour-bar helper
package video_pkg;
    localparam int H_ACTIVE_640       = 640;
    localparam int H_FP_640           = 16;
    localparam int H_SYNC_640         = 96;
    localparam int H_BP_640           = 48;
    localparam int V_ACTIVE_480       = 480;
    localparam int V_FP_480           = 10;
    localparam int V_SYNC_480         = 2;
    localparam int V_BP_480           = 33;
    localparam int CDIV_25M_FROM_100M = 4;
    localparam int MAX_CW             = 8;

    // Everything the output stage needs about one pixel, captured on its fetch tick
    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       fb;
        logic       first;
        logic [2:0] bar;
    } pix_ctl_t;

    // {r,g,b} in MAX_CW-wide slots; only the low cw bits of each slot are ever set
    function automatic logic [3*MAX_CW-1:0] bar_colour(input logic [2:0] i, input int cw);
        logic [MAX_CW-1:0] ones;
        ones = MAX_CW'((1 << cw) - 1);
        return {ones & {MAX_CW{i[2]}}, ones & {MAX_CW{i[1]}}, ones & {MAX_CW{i[0]}}};
    endfunction
endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: pixel-tick divider, h/v raster counters and region decode
// Ports: clk, rst (async, active-high); tick_o one-clk pixel strobe; hc_o/vc_o raster
//        position; active_o visible region; hsync_o/vsync_o raw sync, 1 = in sync pulse
module video_timing_counter
    import video_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_640,
    parameter  int H_FP     = H_FP_640,
    parameter  int H_SYNC   = H_SYNC_640,
    parameter  int H_BP     = H_BP_640,
    parameter  int V_ACTIVE = V_ACTIVE_480,
    parameter  int V_FP     = V_FP_480,
    parameter  int V_SYNC   = V_SYNC_480,
    parameter  int V_BP     = V_BP_480,
    parameter  int CDIV     = CDIV_25M_FROM_100M,
    localparam int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
    localparam int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick_o,
    output logic [HW-1:0] hc_o,
    output logic [VW-1:0] vc_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CDIV);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          tick, h_wrap;

    always_comb begin
        tick   = div_q == DW'(CDIV - 1);
        h_wrap = hc_q == HW'(H_TOT - 1);
        div_d  = tick ? '0 : div_q + DW'(1);
        hc_d   = !tick ? hc_q : h_wrap ? '0 : hc_q + HW'(1);
        vc_d   = !(tick && h_wrap) ? vc_q : (vc_q == VW'(V_TOT - 1)) ? '0 : vc_q + VW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            div_q <= div_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
    end

    assign tick_o   = tick;
    assign hc_o     = hc_q;
    assign vc_o     = vc_q;
    assign active_o = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
    assign hsync_o  = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_o  = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scan-out with framebuffer fetch or colour-bar fallback
// Ports: clk, rst (async, active-high); fb_en selects framebuffer (1) or bars (0);
//        fb_rd/fb_addr/fb_rdata fixed-latency framebuffer read port; r/g/b colour pins;
//        h/v sync pins; frame_start one-clk pulse when pixel (0,0) reaches the pins
module vga_scanout
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_640,
    parameter int H_FP      = H_FP_640,
    parameter int H_SYNC    = H_SYNC_640,
    parameter int H_BP      = H_BP_640,
    parameter int V_ACTIVE  = V_ACTIVE_480,
    parameter int V_FP      = V_FP_480,
    parameter int V_SYNC    = V_SYNC_480,
    parameter int V_BP      = V_BP_480,
    parameter int CDIV      = CDIV_25M_FROM_100M,
    parameter int FETCH_LAT = 2,
    parameter int CW        = 3,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int AW        = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fb_en,
    output logic            fb_rd,
    output logic [AW-1:0]   fb_addr,
    input  logic [3*CW-1:0] fb_rdata,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            h,
    output logic            v,
    output logic            frame_start
);
    localparam int HW  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
    localparam int VW  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);
    localparam int BW  = H_ACTIVE / 8;
    localparam int BCW = $clog2(BW + 1);

    logic                tick, active, hsync, vsync, first;
    logic [HW-1:0]       hc;
    logic [VW-1:0]       vc;
    logic                src_q, src_d, src_cur;
    logic [AW-1:0]       addr_q, addr_d, addr_cur;
    logic [BCW-1:0]      bcnt_q, bcnt_d, bcnt_cur;
    logic [2:0]          bar_q, bar_d, bar_cur;
    logic                bar_last;
    pix_ctl_t            ctl_q, ctl_d;
    logic [FETCH_LAT-1:0] pipe_q, pipe_d;
    logic [3*CW-1:0]     hold_q, hold_d, rgb_q, rgb_d, bar_rgb;
    logic [3*MAX_CW-1:0] bc;
    logic                h_q, h_d, v_q, v_d, fs_q, fs_d;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CDIV     (CDIV)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .tick_o   (tick),
        .hc_o     (hc),
        .vc_o     (vc),
        .active_o (active),
        .hsync_o  (hsync),
        .vsync_o  (vsync)
    );

    // At (0,0) the live fb_en, a zero address and bar 0 are used directly, so a
    // same-clk fb_en toggle is honoured and no wrap logic is needed at frame/line end.
    always_comb begin
        first    = (hc == '0) && (vc == '0);
        src_cur  = first ? fb_en : src_q;
        addr_cur = first ? '0 : addr_q;
        bcnt_cur = (hc == '0) ? '0 : bcnt_q;
        bar_cur  = (hc == '0) ? 3'd0 : bar_q;
        bar_last = bcnt_cur == BCW'(BW - 1);
        fb_rd    = tick && active && src_cur;
        fb_addr  = addr_cur;
        src_d    = (tick && first) ? fb_en : src_q;
        addr_d   = (tick && active) ? addr_cur + AW'(1) : addr_cur;
        bcnt_d   = !(tick && active) ? bcnt_cur : bar_last ? '0 : bcnt_cur + BCW'(1);
        bar_d    = (tick && active && bar_last) ? bar_cur + 3'd1 : bar_cur;
        ctl_d    = tick ? pix_ctl_t'{act: active, hs: hsync, vs: vsync, fb: src_cur,
                                     first: first, bar: bar_cur} : ctl_q;
        // Read strobe delay line; its top bit marks the clk fb_rdata is valid
        pipe_d   = FETCH_LAT'({pipe_q, fb_rd});
        hold_d   = pipe_q[FETCH_LAT-1] ? fb_rdata : hold_q;
        bc       = bar_colour(ctl_q.bar, CW);
        bar_rgb  = {CW'(bc >> (2 * MAX_CW)), CW'(bc >> MAX_CW), CW'(bc)};
        rgb_d    = !tick ? rgb_q : !ctl_q.act ? '0 : ctl_q.fb ? hold_q : bar_rgb;
        h_d      = tick ? (ctl_q.hs ~^ 1'(HS_POL)) : h_q;
        v_d      = tick ? (ctl_q.vs ~^ 1'(VS_POL)) : v_q;
        fs_d     = tick && ctl_q.first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= 1'b0;
            addr_q <= '0;
            bcnt_q <= '0;
            bar_q  <= '0;
            ctl_q  <= '0;
            pipe_q <= '0;
            hold_q <= '0;
            rgb_q  <= '0;
            h_q    <= ~1'(HS_POL);
            v_q    <= ~1'(VS_POL);
            fs_q   <= 1'b0;
        end else begin
            src_q  <= src_d;
            addr_q <= addr_d;
            bcnt_q <= bcnt_d;
            bar_q  <= bar_d;
            ctl_q  <= ctl_d;
            pipe_q <= pipe_d;
            hold_q <= hold_d;
            rgb_q  <= rgb_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fs_q   <= fs_d;
        end
    end

    assign r           = rgb_q[3*CW-1 -: CW];
    assign g           = rgb_q[2*CW-1 -: CW];
    assign b           = rgb_q[CW-1:0];
    assign h           = h_q;
    assign v           = v_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized check of vga_scanout against a clock-count raster model
module tb_vga_scanout;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int CDIV = 3, FL = 2, CW = 3, HP = 0, VP = 1, AW = 8;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FP = HT * VT;

    logic            clk = 0, rst = 1, fb_en = 1;
    logic            fb_rd, h, v, frame_start;
    logic [AW-1:0]   fb_addr;
    logic [3*CW-1:0] fb_rdata = '0;
    logic [CW-1:0]   r, g, b;
    logic            fb_en_nx = 1, rst_nx = 1;
    int              checks = 0, errors = 0, n = 0;
    logic            src_frame[int];
    logic [AW:0]     rdq[$];

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .CDIV (CDIV), .FETCH_LAT (FL), .CW (CW), .HS_POL (HP), .VS_POL (VP), .AW (AW)
    ) dut (
        .clk (clk), .rst (rst), .fb_en (fb_en), .fb_rd (fb_rd), .fb_addr (fb_addr),
        .fb_rdata (fb_rdata), .r (r), .g (g), .b (b), .h (h), .v (v),
        .frame_start (frame_start)
    );

    function automatic logic [8:0] mem(input int a);
        return 9'(a * 37 + 11);
    endfunction

    function automatic logic [8:0] bar_rgb(input int x);
        int i = x / (HA / 8);
        return {i[2] ? 3'd7 : 3'd0, i[1] ? 3'd7 : 3'd0, i[0] ? 3'd7 : 3'd0};
    endfunction

    function automatic bit sof_next();
        return !rst && (n + 2) % CDIV == 0 && ((n + 2) / CDIV - 1) % FP == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // n = clk edges since reset release; pins after edge n show pixel n/CDIV-2
    task automatic cycle();
        int m, p, x, y, j, pj, xj, yj;
        logic exp_rd, exp_h, exp_v, exp_fs;
        logic [8:0] exp_rgb;
        logic [AW:0] e;
        @(posedge clk);
        if (!rst) n++;
        #1;
        fb_en = fb_en_nx;
        rst = rst_nx;
        if (rst) n = 0;
        @(negedge clk);
        exp_rd = 0;
        xj = 0;
        yj = 0;
        if (!rst && (n + 1) % CDIV == 0) begin
            j  = (n + 1) / CDIV - 1;
            pj = j % FP;
            xj = pj % HT;
            yj = pj / HT;
            if (pj == 0) src_frame[j / FP] = fb_en;
            exp_rd = xj < HA && yj < VA && src_frame[j / FP];
        end
        chk("fb_rd", 32'(fb_rd), 32'(exp_rd));
        if (exp_rd) chk("fb_addr", 32'(fb_addr), yj * HA + xj);
        rdq.push_back({fb_rd, fb_addr});
        if (rdq.size() > FL) begin
            e = rdq.pop_front();
            fb_rdata = e[AW] ? mem(int'(e[AW-1:0])) : 9'($urandom);
        end
        exp_rgb = '0;
        exp_h = 1'(HP == 0);
        exp_v = 1'(VP == 0);
        exp_fs = 0;
        if (!rst && n >= 2 * CDIV) begin
            m = n / CDIV - 2;
            p = m % FP;
            x = p % HT;
            y = p / HT;
            if (x < HA && y < VA) exp_rgb = src_frame[m / FP] ? mem(y * HA + x) : bar_rgb(x);
            if (x >= HA + HFP && x < HA + HFP + HSW) exp_h = 1'(HP);
            if (y >= VA + VFP && y < VA + VFP + VSW) exp_v = 1'(VP);
            exp_fs = n % CDIV == 0 && p == 0;
        end
        chk("rgb", 32'({r, g, b}), 32'(exp_rgb));
        chk("h", 32'(h), 32'(exp_h));
        chk("v", 32'(v), 32'(exp_v));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    initial begin
        repeat (10) cycle();
        rst_nx = 0;
        repeat (2 * FP * CDIV) cycle();
        fb_en_nx = 0;
        repeat (FP * CDIV + 50) cycle();
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < FP * CDIV && !sof_next(); t++) cycle();
            fb_en_nx = !fb_en_nx;
            repeat (5) cycle();
        end
        repeat (6 * FP * CDIV) begin
            if ($urandom_range(0, 199) == 0) fb_en_nx = !fb_en_nx;
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(FP * CDIV / 3, FP * CDIV)) cycle();
            rst_nx = 1;
            repeat (3) cycle();
            rst_nx = 0;
            fb_en_nx = 1'($urandom_range(0, 1));
        end
        repeat (3 * FP * CDIV) begin
            if ($urandom_range(0, 149) == 0) fb_en_nx = !fb_en_nx;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine: successor to the fixed 640x480 `video` generator. It derives a pixel tick from the system clock and generates programmable horizontal and vertical timing with selectable sync polarity. It fetches pixels from an external fixed-latency framebuffer port, or falls back to an internal colour-bar pattern. It drives the board's RGB and sync pins directly.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line; must be a multiple of 8.
- `H_FP`, `H_SYNC`, `H_BP`, defaults 16 / 96 / 48: horizontal porch and sync widths, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, `V_SYNC`, `V_BP`, defaults 10 / 2 / 33: vertical porch and sync widths, in lines.
- `CDIV`, default 4: clk cycles per pixel; must be ≥ 2.
- `FETCH_LAT`, default 2: clk cycles from `fb_rd` to valid `fb_rdata`; range 1..CDIV-1.
- `CW`, default 3: bits per colour channel.
- `HS_POL`, `VS_POL`, default 0: active sync level (0 = active-low).
- `AW`, default 19: framebuffer address width; must satisfy 2^AW ≥ H_ACTIVE·V_ACTIVE.
- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `fb_en`, in, 1: 1 = framebuffer source, 0 = colour bars.
- `fb_rd`, out, 1: one-clk read strobe.
- `fb_addr`, out, AW: linear pixel address, y·H_ACTIVE + x.
- `fb_rdata`, in, 3·CW: pixel data {r,g,b}; sampled FETCH_LAT clks after `fb_rd`.
- `r`, `g`, `b`, out, CW each: colour outputs; 0 when blanked.
- `h`, `v`, out, 1: horizontal and vertical sync.
- `frame_start`, out, 1: one-clk pulse at the first active pixel of each frame.

## Operation
- **Divider:** `div` counts 0..CDIV-1 continuously. `tick` = (div == CDIV-1).
- **Counters:** on each `tick`, `hc` increments and wraps at H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP. When `hc` wraps, `vc` increments and wraps at V_TOT.
- **Region decode:**
  - Active region: hc < H_ACTIVE and vc < V_ACTIVE.
  - hsync asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for the equivalent range of `vc`.
- **Source latch:** a frame-source flag is loaded from `fb_en` only on the tick where hc=0, vc=0. A change of `fb_en` mid-frame takes effect at the next frame.
- **Fetch:** `fb_rd` = tick & active & source flag. `fb_addr` comes from a running register:
  - cleared on the tick at hc=0, vc=0;
  - incremented after each active pixel.
  - No multiplier.
- **Colour bars:** the bar index 0..7 advances every H_ACTIVE/8 active pixels and resets at hc=0. Bar i gives r = {CW{i[2]}}, g = {CW{i[1]}}, b = {CW{i[0]}}.
- **Pixel capture:** `fb_rdata` is captured into a hold register exactly FETCH_LAT clks after `fb_rd`.
- **Output stage:** on the next `tick`, registered outputs load:
  - colour = hold register, bar colour, or 0 when not active;
  - `h`, `v` = decoded sync XNOR the polarity parameter.
- `frame_start` pulses for one clk together with the output update for pixel (0,0).

## Timing
- **Reset values:**
  - `div`, `hc`, `vc`, address and bar counters = 0; source flag = 0.
  - `r`, `g`, `b` = 0; `fb_rd` = 0; `frame_start` = 0.
  - `h` = ~HS_POL, `v` = ~VS_POL.
- **Reset release:** the first `tick` occurs CDIV clks after `rst` deasserts.
- **Latency:** exactly one pixel tick (CDIV clks) from counter state to pins. Colour and sync stay aligned for all parameter values.
- **Period:** frame = H_TOT·V_TOT·CDIV clks. With defaults: 800·525·4 = 1 680 000 clks.
- **Reset mid-frame:** all state and outputs return to reset values immediately (asynchronously). No `fb_rd` is issued while `rst` is high. Any outstanding read data is ignored.
- **`fb_en` at the frame boundary:** a toggle on the same clk as the hc=0, vc=0 tick is sampled with its new value.

## Structure
- **Package `video_pkg`:**
  - default 640x480@60 timing constants;
  - a 25 MHz-from-100 MHz CDIV constant;
  - a `bar_colour(i, CW)` function.
- **Sub-module `video_timing_counter`:** divider, hc/vc counters, active/sync decode and tick output. It is reused by later display blocks.
- **Top level:** fetch, bar generation, capture and output registers.

## Test plan
- **Reset values:** hold `rst` for 100 ns. Required: `h`=1, `v`=1, rgb=0 and `fb_rd`=0 throughout; first `tick` 4 clks after release.
- **Small-timing sync:** H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP/V_SYNC/V_BP=1, CDIV=2. Required:
  - `h` low for exactly 4 clks per 24-clk line;
  - `v` low for exactly 1 line;
  - frame = 120 clks.
- **Framebuffer source:** `fb_en`=1, model returns `fb_rdata` = address[8:0] after FETCH_LAT. Required:
  - 307 200 `fb_rd` strobes per default frame;
  - `fb_addr` runs 0..307199;
  - rgb on pixel (5,1) equals 645[8:0].
- **Colour bars:** `fb_en`=0 with defaults. Required:
  - pixels 0–79 black;
  - pixels 560–639 rgb = 7/7/7;
  - no `fb_rd` strobes.
- **Mid-frame source switch:** toggle `fb_en` at line 100. Required: source changes only after the next `frame_start`.
- **Reset mid-frame:** assert `rst` at line 200 for 3 clks. Required: outputs at reset values immediately; the frame restarts from (0,0) after release.
